// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the instruction-fetch stage.
//   DEF_ADDR_W / DEF_INSTR_W : default address and instruction widths
//   fetch_state_t            : fetch control FSM encoding
//   NOP_INSTR                : canonical no-op word (addi x0,x0,0) for ROM filling
package fetch_pkg;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: signals between the fetch stage and its neighbours
// (PC register, instruction ROM, decode, execute redirect).
//   master : the fetch stage
//   slave  : the surrounding pipeline / environment
//   pc, next_pc                        PC register feedback
//   imem_addr, imem_en, imem_rdata     ROM read port (1-cycle latency)
//   instr_valid, instr, instr_pc,
//   instr_ready                        decode handshake
//   redir_valid, redir_pc              branch/jump redirect from execute
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               redir_valid;
    logic [ADDR_W-1:0]  redir_pc;

    modport master (
        input  pc, imem_rdata, instr_ready, redir_valid, redir_pc,
        output next_pc, imem_addr, imem_en, instr_valid, instr, instr_pc
    );

    modport slave (
        output pc, imem_rdata, instr_ready, redir_valid, redir_pc,
        input  next_pc, imem_addr, imem_en, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: small synchronous FIFO of {instruction, pc} pairs.
//   clk, reset            clock, synchronous active-high reset
//   push, push_instr,
//   push_pc               write one entry
//   pop                   remove the head entry
//   flush                 drop every entry; wins over push
//   count                 number of stored entries
//   head_valid, head_instr,
//   head_pc               oldest entry (zero when empty)
module fetch_buf #(
    parameter int DEPTH   = 2,
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [INSTR_W-1:0]     push_instr,
    input  logic [ADDR_W-1:0]      push_pc,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [INSTR_W-1:0]     head_instr,
    output logic [ADDR_W-1:0]      head_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_pop;
    logic               do_push;

    // Pop only real entries; a push into a full buffer is accepted only
    // when a pop frees a slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset so it can map onto plain registers/LUT-RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    // Head reads as zero when empty, which also gives zero outputs after reset.
    assign head_valid = (count != '0);
    assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch around the PC register.
//   clk, reset   clock, synchronous active-high reset
//   bus          fetch_if.master:
//                  pc in / next_pc out (combinational PC register input)
//                  imem_addr = pc, imem_en = fetch issued this cycle,
//                  imem_rdata returned one cycle after imem_en
//                  instr_valid/instr/instr_pc/instr_ready toward decode
//                  redir_valid/redir_pc from execute (flushes everything)
// A fetch is only issued when the buffer is sure to have room for its
// response, so the buffer never overflows and a response is never dropped
// except by a redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic               pend;
    logic [ADDR_W-1:0]  pend_pc;
    logic               issue;
    logic [ADDR_W-1:0]  next_pc;
    logic               credit_ok;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   count;
    logic               head_valid;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               pop;
    logic               push;
    logic               flush;

    assign pop   = head_valid && bus.instr_ready;
    assign flush = bus.redir_valid;
    // A response landing in a redirect cycle belongs to the squashed path.
    assign push  = pend && !bus.redir_valid;

    // Entries the buffer will hold once the in-flight response lands and
    // this cycle's pop retires; a new fetch needs one more free slot.
    assign occ       = count + CNT_W'(pend) - CNT_W'(pop);
    assign credit_ok = (occ < CNT_W'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        next_pc   = bus.pc;
        if (reset) begin
            state_nxt = IDLE;
            next_pc   = '0;
        end else if (bus.redir_valid) begin
            state_nxt = FETCH;
            next_pc   = bus.redir_pc;
        end else begin
            case (state)
                IDLE: state_nxt = FETCH;
                FETCH, HOLD: begin
                    if (credit_ok) begin
                        issue     = 1'b1;
                        next_pc   = bus.pc + ADDR_W'(1);
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // pend marks a ROM response arriving next cycle; pend_pc is its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_pc <= '0;
        end else begin
            pend <= issue;
            if (issue) pend_pc <= bus.pc;
        end
    end

    fetch_buf #(
        .DEPTH   (BUF_DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_instr (bus.imem_rdata),
        .push_pc    (pend_pc),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head_valid (head_valid),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    assign bus.next_pc     = next_pc;
    assign bus.imem_addr   = bus.pc;
    assign bus.imem_en     = issue;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a
// queue-based reference model of the fetch rules (issue credit, 1-cycle ROM,
// buffer FIFO, redirect flush, reset).
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int AW    = 4;
    localparam int IW    = 32;
    localparam int DEPTH = 2;
    localparam int VW    = 1 + AW + AW + 1 + IW + AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus();

    fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .BUF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [IW-1:0] rom [16];

    // PC register and 1-cycle-latency ROM around the stage
    always @(posedge clk) bus.pc <= bus.next_pc;
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

    // reference model state
    logic [IW+AW-1:0] mq[$];
    int               m_pend;
    logic [AW-1:0]    m_pend_pc;
    bit               m_idle;
    int               m_pops, obs_pops;
    logic [VW-1:0]    exp_vec, obs_vec;
    int               n_vec, n_err;

    // One clock: drive inputs after negedge, let logic settle, compute the
    // model's expected outputs for this cycle and advance the model.
    task automatic tick(input logic r, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
        bit            m_pop, m_issue, e_valid;
        logic [AW-1:0] e_next;
        logic [IW+AW-1:0] head;
        @(negedge clk);
        reset = r; bus.instr_ready = rdy; bus.redir_valid = rv; bus.redir_pc = rpc;
        #1;
        e_valid = (mq.size() > 0);
        head    = e_valid ? mq[0] : '0;
        m_pop   = e_valid && rdy;
        if (r) begin
            m_issue = 0; e_next = '0;
        end else begin
            m_issue = !m_idle && !rv && ((int'(mq.size()) + m_pend - int'(m_pop)) < DEPTH);
            e_next  = rv ? rpc : (m_issue ? AW'(bus.pc + 1) : bus.pc);
        end
        exp_vec = {m_issue, e_next, bus.pc, e_valid, head};
        obs_vec = {bus.imem_en, bus.next_pc, bus.imem_addr, bus.instr_valid,
                   (bus.instr_valid === 1'b1) ? {bus.instr, bus.instr_pc} : {(IW+AW){1'b0}}};
        if (!r && bus.instr_valid === 1'b1 && rdy) obs_pops++;
        if (r) begin
            mq.delete(); m_pend = 0; m_idle = 1;
        end else begin
            if (m_pop) begin void'(mq.pop_front()); m_pops++; end
            if (rv) mq.delete();
            else if (m_pend != 0) mq.push_back({rom[m_pend_pc], m_pend_pc});
            m_pend = int'(m_issue);
            if (m_issue) m_pend_pc = bus.pc;
            m_idle = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) rom[i] = IW'(i);
        tick(1, 1, 0, 0);
        n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec); end
        n_vec++; if ({dut.state, dut.u_buf.count, dut.pend} !== {IDLE, 2'd0, 1'b0})
            begin n_err++; $display("FAIL reset_state: got %0d/%0d/%0d want 0/0/0", dut.state, dut.u_buf.count, dut.pend); end
        for (int c = 0; c < 8; c++) begin
            tick(0, 1, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL reset_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
            if (c < 3) begin
                n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_early_valid c%0d: got %b want 0", c, bus.instr_valid); end
            end
            if (c == 3) begin
                n_vec++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 32'd0, 4'd0})
                    begin n_err++; $display("FAIL reset_first: got %b/%h/%0d want 1/0/0", bus.instr_valid, bus.instr, bus.instr_pc); end
            end
            if (c >= 4 && c <= 6) begin
                n_vec++; if ({bus.instr_valid, bus.instr_pc} !== {1'b1, AW'(c - 3)})
                    begin n_err++; $display("FAIL reset_seq c%0d: got %b/%0d want 1/%0d", c, bus.instr_valid, bus.instr_pc, c - 3); end
            end
            if (c >= 1) begin
                n_vec++; if (bus.next_pc !== AW'(bus.pc + 1)) begin n_err++; $display("FAIL reset_nextpc c%0d: got %0d want %0d", c, bus.next_pc, AW'(bus.pc + 1)); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [4*AW-1:0] last4 = '0;
        bit saw_seq = 0;
        for (int c = 0; c < 24; c++) begin
            tick(0, 1, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL wrap_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
            if (bus.instr_valid === 1'b1) last4 = {last4[3*AW-1:0], bus.instr_pc};
            if (last4 == {4'd14, 4'd15, 4'd0, 4'd1}) saw_seq = 1;
            if (bus.pc == 4'd15 && bus.imem_en === 1'b1) begin
                n_vec++; if (bus.next_pc !== 4'd0) begin n_err++; $display("FAIL wrap_nextpc: got %0d want 0", bus.next_pc); end
            end
        end
        n_vec++; if (saw_seq !== 1'b1) begin n_err++; $display("FAIL wrap_seq: got %b want 1 (14,15,0,1)", saw_seq); end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] h_instr;
        logic [AW-1:0] h_pc;
        for (int c = 0; c < 5; c++) begin
            tick(0, 0, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bp_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
            if (c == 0) begin h_instr = bus.instr; h_pc = bus.instr_pc; end
            else begin
                n_vec++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, h_instr, h_pc})
                    begin n_err++; $display("FAIL bp_stable c%0d: got %h/%0d want %h/%0d", c, bus.instr, bus.instr_pc, h_instr, h_pc); end
            end
            if (c >= 2) begin
                n_vec++; if ({dut.u_buf.count, dut.pend, bus.imem_en, dut.state} !== {2'd2, 1'b0, 1'b0, HOLD} || bus.next_pc !== bus.pc)
                    begin n_err++; $display("FAIL bp_hold c%0d: got cnt %0d pend %0d en %0d st %0d npc %0d pc %0d want 2/0/0/HOLD/npc=pc",
                        c, dut.u_buf.count, dut.pend, bus.imem_en, dut.state, bus.next_pc, bus.pc); end
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick(0, 1, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bp_drain_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
            n_vec++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, AW'(h_pc + c), rom[AW'(h_pc + c)]})
                begin n_err++; $display("FAIL bp_drain c%0d: got %b/%0d want 1/%0d", c, bus.instr_valid, bus.instr_pc, AW'(h_pc + c)); end
        end
    endtask

    task automatic test_redirect_inflight();
        n_vec++; if ({dut.u_buf.count, dut.pend} !== {2'd1, 1'b1})
            begin n_err++; $display("FAIL redir_pre: got cnt %0d pend %0d want 1/1", dut.u_buf.count, dut.pend); end
        tick(0, 0, 1, 4'd9);
        n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL redir_model N: got %h want %h", obs_vec, exp_vec); end
        for (int c = 1; c <= 5; c++) begin
            tick(0, 1, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL redir_model N+%0d: got %h want %h", c, obs_vec, exp_vec); end
            if (c == 1) begin
                n_vec++; if ({bus.instr_valid, bus.imem_addr, bus.imem_en} !== {1'b0, 4'd9, 1'b1})
                    begin n_err++; $display("FAIL redir_n1: got v%b addr %0d en %b want v0 addr 9 en 1", bus.instr_valid, bus.imem_addr, bus.imem_en); end
            end
            if (c == 2) begin
                n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_n2_valid: got %b want 0", bus.instr_valid); end
            end
            if (c >= 3) begin
                n_vec++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, AW'(9 + c - 3), rom[AW'(9 + c - 3)]})
                    begin n_err++; $display("FAIL redir_target N+%0d: got %b/%0d want 1/%0d", c, bus.instr_valid, bus.instr_pc, 9 + c - 3); end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [AW-1:0] tgt = AW'($urandom_range(0, 15));
        n_vec++; if ({dut.u_buf.count, dut.pend, bus.instr_valid} !== {2'd1, 1'b1, 1'b1})
            begin n_err++; $display("FAIL simul_pre: got cnt %0d pend %0d v %b want 1/1/1", dut.u_buf.count, dut.pend, bus.instr_valid); end
        tick(0, 1, 1, tgt);
        n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL simul_model N: got %h want %h", obs_vec, exp_vec); end
        for (int c = 1; c <= 3; c++) begin
            tick(0, 1, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL simul_model N+%0d: got %h want %h", c, obs_vec, exp_vec); end
            if (c == 1) begin
                n_vec++; if ({dut.u_buf.count, bus.instr_valid} !== {2'd0, 1'b0})
                    begin n_err++; $display("FAIL simul_flush: got cnt %0d v %b want 0/0", dut.u_buf.count, bus.instr_valid); end
            end
            if (c == 3) begin
                n_vec++; if ({bus.instr_valid, bus.instr_pc} !== {1'b1, tgt})
                    begin n_err++; $display("FAIL simul_target: got %b/%0d want 1/%0d", bus.instr_valid, bus.instr_pc, tgt); end
            end
        end
        n_vec++; if (obs_pops !== m_pops) begin n_err++; $display("FAIL simul_pops: got %0d want %0d", obs_pops, m_pops); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            tick(0, 0, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rmid_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
        end
        n_vec++; if (dut.u_buf.count !== 2'd2) begin n_err++; $display("FAIL rmid_full: got %0d want 2", dut.u_buf.count); end
        // no fetch is in flight here, so the ROM can be reloaded safely
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        rom[0] = NOP_INSTR;
        tick(1, 0, 0, 0);
        n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rmid_model rst: got %h want %h", obs_vec, exp_vec); end
        for (int c = 0; c < 6; c++) begin
            tick(0, 1, 0, 0);
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rmid_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
            if (c == 0) begin
                n_vec++; if ({bus.instr_valid, dut.u_buf.count, dut.pend, dut.state} !== {1'b0, 2'd0, 1'b0, IDLE})
                    begin n_err++; $display("FAIL rmid_cleared: got v%b cnt %0d pend %0d st %0d want 0/0/0/IDLE", bus.instr_valid, dut.u_buf.count, dut.pend, dut.state); end
            end
            if (c == 3) begin
                n_vec++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, NOP_INSTR, 4'd0})
                    begin n_err++; $display("FAIL rmid_restart: got %b/%h/%0d want 1/%h/0", bus.instr_valid, bus.instr, bus.instr_pc, NOP_INSTR); end
            end else if (c < 3) begin
                n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_early c%0d: got %b want 0", c, bus.instr_valid); end
            end
        end
    endtask

    task automatic test_random();
        bit rv = 0;
        for (int c = 0; c < 500; c++) begin
            bit r   = ($urandom_range(0, 99) == 0);
            bit rdy = ($urandom_range(0, 3) != 0);
            rv = rv ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
            tick(r, rdy, rv, AW'($urandom_range(0, 15)));
            n_vec++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rand_model c%0d: got %h want %h", c, obs_vec, exp_vec); end
        end
        n_vec++; if (obs_pops !== m_pops) begin n_err++; $display("FAIL rand_pops: got %0d want %0d", obs_pops, m_pops); end
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_pops = 0; obs_pops = 0;
        m_pend = 0; m_pend_pc = '0; m_idle = 1;
        bus.instr_ready = 1'b1; bus.redir_valid = 1'b0; bus.redir_pc = '0;
        for (int i = 0; i < 16; i++) rom[i] = IW'(i);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_wrap();
        test_backpressure();
        test_redirect_inflight();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
